// File: rtl/deserializer_out.sv
// Serial-to-parallel receiver that rebuilds 27-bit frames (three K+8 words) from a bit/enable
// stream, buffers them in a FWFT FIFO with valid/ready output, flags truncation and overflow.
module deserializer_out #(
  parameter int FRAME_W    = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          data_i,
  input  logic                          ena_i,
  output logic [31:0]                   frame_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          err_o,
  output logic                          ovf_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [4:0] LAST_BIT = 5'(FRAME_W - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e               state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [FRAME_W-2:0]   shreg_q, shreg_d;
  logic                 push, pop, full, wr_en;
  logic                 err_d, err_q, ovf_d, ovf_q;
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic [FRAME_W-1:0]   mem_q [FIFO_DEPTH];
  logic [FRAME_W-1:0]   head;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    push    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ena_i) begin
          shreg_d = {shreg_q[FRAME_W-3:0], data_i};
          cnt_d   = 5'd1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!ena_i) begin
          err_d   = 1'b1;
          cnt_d   = 5'd0;
          state_d = IDLE;
        end else if (cnt_q == LAST_BIT) begin
          // The final bit goes straight into the FIFO word; shreg already holds the other 26.
          push    = 1'b1;
          cnt_d   = 5'd0;
          state_d = IDLE;
        end else begin
          shreg_d = {shreg_q[FRAME_W-3:0], data_i};
          cnt_d   = cnt_q + 5'd1;
        end
      end
    endcase
  end

  always_comb begin
    full    = (level_q == LW'(FIFO_DEPTH));
    pop     = (level_q != '0) && ready_i;
    wr_en   = push && (!full || pop);
    ovf_d   = push && full && !pop;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (wr_en) wptr_d = wptr_q + AW'(1);
    if (pop)   rptr_d = rptr_q + AW'(1);
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is left unreset; the head is masked by valid_o instead.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= {shreg_q, data_i};
  end

  assign head    = mem_q[rptr_q];
  assign valid_o = (level_q != '0);
  assign frame_o = valid_o ? 32'(head) : 32'd0;
  assign level_o = level_q;
  assign err_o   = err_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_deserializer_out.sv
// Bench for deserializer_out: directed vector table, hand sequences, and randomized traffic
// checked every cycle against a queue-based frame model.
module tb_deserializer_out;

  logic        clk_i = 1'b0;
  logic        rst_ni, data_i, ena_i, ready_i;
  logic [31:0] frame_o;
  logic        valid_o, err_o, ovf_o;
  logic [2:0]  level_o;

  int n_cmp = 0;
  int n_bad = 0;

  deserializer_out #(.FRAME_W(27), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_i), .ena_i(ena_i),
    .frame_o(frame_o), .valid_o(valid_o), .ready_i(ready_i),
    .level_o(level_o), .err_o(err_o), .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // Reference model: bits collected so far plus a queue of stored frames.
  int          m_n = 0;
  logic [26:0] m_acc = '0;
  logic [26:0] m_q[$];
  logic        m_err = 1'b0, m_ovf = 1'b0;

  task automatic model_reset();
    m_n = 0; m_q.delete(); m_err = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic d, input logic r);
    logic was_full, popped, done;
    was_full = (m_q.size() == 4);
    popped   = (m_q.size() != 0) && r;
    done     = 1'b0;
    m_err = 1'b0; m_ovf = 1'b0;
    if (e) begin
      m_acc = {m_acc[25:0], d};
      m_n++;
      if (m_n == 27) begin done = 1'b1; m_n = 0; end
    end else if (m_n != 0) begin
      m_err = 1'b1; m_n = 0;
    end
    if (popped) void'(m_q.pop_front());
    if (done) begin
      if (was_full && !popped) m_ovf = 1'b1;
      else m_q.push_back(m_acc);
    end
  endtask

  function automatic logic [37:0] model_out();
    logic [31:0] f;
    f = (m_q.size() != 0) ? {5'b0, m_q[0]} : 32'd0;
    return {m_q.size() != 0, f, 3'(m_q.size()), m_err, m_ovf};
  endfunction

  function automatic logic [37:0] dut_out();
    return {valid_o, frame_o, level_o, err_o, ovf_o};
  endfunction

  task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got valid=%0b frame=%h level=%0d err=%0b ovf=%0b, want valid=%0b frame=%h level=%0d err=%0b ovf=%0b",
               name, act[37], act[36:5], act[4:2], act[1], act[0],
               exp[37], exp[36:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs checked.
  task automatic tick(input logic e, input logic d, input logic r);
    ena_i = e; data_i = d; ready_i = r;
    @(posedge clk_i);
    model_step(e, d, r);
    @(negedge clk_i);
    check("model", dut_out(), model_out());
  endtask

  task automatic send(input logic [26:0] f, input int nbits, input logic r);
    for (int i = 0; i < nbits; i++) tick(1'b1, f[26-i], r);
  endtask

  typedef struct {
    logic [26:0] frm;
    int          nbits;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_frame;
    logic [2:0]  exp_level;
    logic        exp_err;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[6];
  logic [31:0] drain_exp[4];

  initial begin
    vecs[0] = '{27'h6F0AAA3, 27, 1'b0, 1'b1, 32'h06F0_AAA3, 3'd1, 1'b0, 1'b0};
    vecs[1] = '{27'h1234567, 10, 1'b0, 1'b1, 32'h06F0_AAA3, 3'd1, 1'b1, 1'b0};
    vecs[2] = '{27'h0000155, 27, 1'b0, 1'b1, 32'h06F0_AAA3, 3'd2, 1'b0, 1'b0};
    vecs[3] = '{27'h7FFFFFF, 27, 1'b0, 1'b1, 32'h06F0_AAA3, 3'd3, 1'b0, 1'b0};
    vecs[4] = '{27'h5555555, 27, 1'b0, 1'b1, 32'h06F0_AAA3, 3'd4, 1'b0, 1'b0};
    vecs[5] = '{27'h2AAAAAA, 27, 1'b0, 1'b1, 32'h06F0_AAA3, 3'd4, 1'b0, 1'b1};
    drain_exp[0] = 32'h0000_0155;
    drain_exp[1] = 32'h07FF_FFFF;
    drain_exp[2] = 32'h0555_5555;
    drain_exp[3] = 32'h0123_4567;

    rst_ni = 1'b0; ena_i = 1'b0; data_i = 1'b0; ready_i = 1'b0;
    #1;
    check("reset_state", dut_out(), 38'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    tick(1'b0, 1'b0, 1'b0);

    // Table: single frame, truncation, fill to full, overflow.
    for (int k = 0; k < 6; k++) begin
      send(vecs[k].frm, vecs[k].nbits, vecs[k].rdy);
      if (vecs[k].nbits < 27) tick(1'b0, 1'b0, vecs[k].rdy);
      check($sformatf("vec%0d", k), dut_out(),
            {vecs[k].exp_valid, vecs[k].exp_frame, vecs[k].exp_level, vecs[k].exp_err, vecs[k].exp_ovf});
      tick(1'b0, 1'b0, 1'b0);
    end

    // Full FIFO: pop coincides with the completing bit of a new frame.
    send(27'h1234567, 26, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    check("full_push_pop", dut_out(), {1'b1, 32'h0000_0155, 3'd4, 1'b0, 1'b0});
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d", k), dut_out(), {1'b1, drain_exp[k], 3'(4 - k), 1'b0, 1'b0});
      tick(1'b0, 1'b0, 1'b1);
    end
    check("drained", dut_out(), 38'd0);
    tick(1'b0, 1'b0, 1'b1);
    check("ready_when_empty", dut_out(), 38'd0);

    // Back-to-back frames with ready held high.
    send(27'h6F0AAA3, 27, 1'b1);
    check("b2b_first", dut_out(), {1'b1, 32'h06F0_AAA3, 3'd1, 1'b0, 1'b0});
    tick(1'b1, 1'b0, 1'b1);
    check("b2b_popped", dut_out(), {1'b0, 32'd0, 3'd0, 1'b0, 1'b0});
    send(27'h0000155 << 1, 26, 1'b1);
    check("b2b_second", dut_out(), {1'b1, 32'h0000_0155, 3'd1, 1'b0, 1'b0});
    tick(1'b0, 1'b0, 1'b1);
    check("b2b_empty", dut_out(), 38'd0);

    // Reset in the middle of a frame with a frame already stored.
    send(27'h7FFFFFF, 27, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    send(27'h1234567, 15, 1'b0);
    rst_ni = 1'b0;
    #1;
    check("mid_reset", dut_out(), 38'd0);
    model_reset();
    ena_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    check("post_reset_no_err", dut_out(), 38'd0);
    send(27'h6F0AAA3, 27, 1'b0);
    check("post_reset_frame", dut_out(), {1'b1, 32'h06F0_AAA3, 3'd1, 1'b0, 1'b0});

    // Randomized traffic against the model.
    for (int it = 0; it < 120; it++) begin
      int kind, len;
      kind = $urandom_range(0, 3);
      len  = (kind == 0) ? $urandom_range(1, 26) : 27;
      for (int b = 0; b < len; b++)
        tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
      for (int g = $urandom_range((kind == 0) ? 1 : 0, 2); g > 0; g--)
        tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
    end
    repeat (6) tick(1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/deserializer_out.md
# deserializer_out

Serial-to-parallel receive stage that consumes the bit stream and bit-enable produced by the serializer stage. It reassembles 27-bit frames made of three 9-bit words, each word being a K flag plus 8 data bits. Completed frames are buffered in a small first-word-fall-through FIFO with a valid/ready output handshake, ready for a Wishbone wrapper or a downstream consumer. Truncated frames and FIFO overflow are flagged.

## Interface
- FRAME_W, 27: bits per frame; three 9-bit words.
- FIFO_DEPTH, 4: frame buffer depth; power of two, ≥2.
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- data_i  input  1  serial bit; sampled only when ena_i=1.
- ena_i  input  1  bit strobe; high for each valid bit of a frame.
- frame_o  output  32  head-of-FIFO frame, {5'b0, word2[26:18], word1[17:9], word0[8:0]}; each word is {k, data[7:0]}; forced to 0 when valid_o=0.
- valid_o  output  1  FIFO not empty.
- ready_i  input  1  consumer accepts the head frame when valid_o & ready_i.
- level_o  output  $clog2(FIFO_DEPTH)+1  number of frames stored.
- err_o  output  1  one-cycle pulse: frame truncated.
- ovf_o  output  1  one-cycle pulse: completed frame dropped because FIFO was full.

## Operation
- Bit order is MSB first. The first sampled bit lands in frame bit 26; the 27th sampled bit lands in bit 0.
- Receive FSM has two states, IDLE and SHIFT. It uses a 5-bit bit counter `cnt` and a 26-bit shift register.
  - IDLE: if ena_i=1, shift in data_i, set cnt=1, go to SHIFT. Otherwise hold.
  - SHIFT, ena_i=1, cnt<26: shift in data_i, cnt++.
  - SHIFT, ena_i=1, cnt==26: form frame {shreg, data_i} and push it to the FIFO. Set cnt=0 and go to IDLE.
  - SHIFT, ena_i=0: the frame is truncated. Discard partial bits, pulse err_o, set cnt=0, go to IDLE.
- Back-to-back frames are allowed. An ena_i=1 in the cycle after a 27th bit starts the next frame from IDLE with no gap.
- FIFO is first-word-fall-through.
  - Push happens on the completing bit.
  - Pop happens when valid_o & ready_i.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - level_o is a registered count.
- Full FIFO with push and no pop: the frame is dropped, ovf_o pulses, and FIFO contents are unchanged.
- Full FIFO with push and pop in the same cycle: both are performed, level_o is unchanged, and there is no ovf_o.
- Empty FIFO with push: there is no bypass. ready_i is irrelevant that cycle.
- ready_i while valid_o=0 is ignored; no pointer movement.
- No data checking. K flags are passed through unmodified.

## Timing
- Reset values (asynchronous, while rst_ni=0):
  - FSM = IDLE, cnt=0, shreg=0, pointers and level = 0.
  - valid_o=0, frame_o=0, level_o=0, err_o=0, ovf_o=0.
  - FIFO storage need not be reset; frame_o is gated by valid_o.
- Reset mid-frame aborts the frame silently: no err_o. After release, the first ena_i=1 starts a new frame.
- Latency: the 27th bit is sampled at edge N. valid_o, frame_o and level_o reflect the frame after edge N, i.e. visible in cycle N+1.
- err_o and ovf_o are registered. They are high for exactly the one cycle following the triggering edge.
- Pop at edge M: the next frame (if any) appears on frame_o after edge M; level_o decrements after edge M.
- Throughput: one frame per 27 cycles sustained, with no lost bits between frames.

## Test plan
- **Single frame.** Send {9'h1BC, 9'h055, 9'h0A3} MSB first with ena_i held high for 27 cycles, ready_i=0.
  - One cycle after the 27th bit: valid_o=1, frame_o=32'h06F0_AAA3, level_o=1, err_o=0.
- **Back-to-back frames.** Send two frames with no gap: 27'h6F0AAA3 then 27'h0000155; ready_i=1 throughout.
  - frame_o shows 32'h06F0_AAA3 for one cycle, then after 27 more cycles 32'h0000_0155.
  - Both frames are popped; level_o returns to 0.
- **Truncation.** Deassert ena_i after 10 bits.
  - err_o pulses for one cycle; level_o stays 0.
  - A following full frame 27'h6F0AAA3 is received intact.
- **Overflow.** Send 5 frames with ready_i=0, FIFO_DEPTH=4.
  - level_o saturates at 4; ovf_o pulses once on the 5th frame.
  - Draining yields the first 4 frames in order.
- **Full with simultaneous pop.** With the FIFO full, assert ready_i=1 on the cycle the 27th bit of a new frame arrives.
  - level_o stays 4 and there is no ovf_o.
  - The new frame is read out last.
- **Reset mid-frame.** Pull rst_ni low after 15 bits, then release.
  - All outputs are 0 immediately, with no err_o.
  - A new 27-bit frame afterwards is received correctly.
